lsu_controller: RTL and testbench

Sequences load/store instructions from the execute stage onto a single-port data memory bus with a req/gnt/rvalid handshake. Computes the effective address, byte enables and lane-aligned store data, and formats load data (sign/zero extension) for writeback. Detects misaligned or illegal accesses and memory timeouts. It sits between the execute stage and the data memory and stalls the pipeline while a transaction is in flight.

---
 rtl/lsu_pkg.sv | 42 ++++
 rtl/lsu_align.sv | 52 +++++
 rtl/lsu_controller.sv | 156 +++++++++++++++
 tb/tb_lsu_controller.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: funct3 encodings,
// FSM states, fault causes and access sizes, plus legality/alignment helpers.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_RSP = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    CAUSE_MISALIGNED = 2'd0,
    CAUSE_ILLEGAL    = 2'd1,
    CAUSE_TIMEOUT    = 2'd2
  } fault_cause_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } access_size_t;

  function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
    if (is_load) return (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
    return (f3 == SB) || (f3 == SH) || (f3 == SW);
  endfunction

  // Size lives in funct3[1:0] for both loads and stores.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    return ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables and store-lane replication for the
// outgoing access, byte/half extraction with sign/zero extension for loads.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_addr_lo_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic [2:0]  ld_func3_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] byte_shift;
  logic [31:0] half_shift;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = st_data_i;
    case (access_size_t'(st_size_i))
      SZ_BYTE: begin
        be_o    = 4'b0001 << st_addr_lo_i;
        wdata_o = {4{st_data_i[7:0]}};
      end
      SZ_HALF: begin
        be_o    = 4'b0011 << st_addr_lo_i;
        wdata_o = {2{st_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_shift = rdata_i >> {ld_addr_lo_i, 3'b000};
    half_shift = rdata_i >> {ld_addr_lo_i[1], 4'b0000};
    ld_byte    = byte_shift[7:0];
    ld_half    = half_shift[15:0];
    case (ld_func3_i)
      LB:      ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      LH:      ld_data_o = {{16{ld_half[15]}}, ld_half};
      LBU:     ld_data_o = {24'h0, ld_byte};
      LHU:     ld_data_o = {16'h0, ld_half};
      default: ld_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_controller.sv
// Load/store sequencer: accepts one access from execute, drives a req/gnt/rvalid
// data bus, and returns formatted load data or a fault pulse.
module lsu_controller
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int XLEN           = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic            load_enable,
  input  logic            store_enable,
  input  logic [XLEN-1:0] base_addr,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] store_data,
  input  logic [2:0]      func3,
  output logic            mem_req,
  input  logic            mem_gnt,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_data,
  output logic            fault,
  output logic [1:0]      fault_cause
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  lsu_state_t      state_q;
  logic [1:0]      addr_lo_q;
  logic [2:0]      func3_q;
  logic [TW-1:0]   tmo_q;
  logic            mem_req_q, mem_we_q, wb_valid_q, fault_q;
  logic [XLEN-1:0] mem_addr_q, mem_wdata_q, wb_data_q;
  logic [3:0]      mem_be_q;
  fault_cause_t    cause_q;

  logic [XLEN-1:0] eff_addr_d;
  logic [3:0]      be_d;
  logic [XLEN-1:0] wdata_d;
  logic [XLEN-1:0] ld_data_d;

  assign eff_addr_d = base_addr + imm;

  lsu_align u_align (
    .st_size_i    (func3[1:0]),
    .st_addr_lo_i (eff_addr_d[1:0]),
    .st_data_i    (store_data),
    .be_o         (be_d),
    .wdata_o      (wdata_d),
    .ld_func3_i   (func3_q),
    .ld_addr_lo_i (addr_lo_q),
    .rdata_i      (mem_rdata),
    .ld_data_o    (ld_data_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_lo_q   <= '0;
      func3_q     <= '0;
      tmo_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
      fault_q     <= 1'b0;
      cause_q     <= CAUSE_MISALIGNED;
    end else begin
      wb_valid_q <= 1'b0;
      fault_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ex_valid && (load_enable || store_enable)) begin
            if (load_enable && store_enable) begin
              fault_q <= 1'b1;
              cause_q <= CAUSE_ILLEGAL;
            end else if (!f3_legal(load_enable, func3)) begin
              fault_q <= 1'b1;
              cause_q <= CAUSE_ILLEGAL;
            end else if (is_misaligned(func3, eff_addr_d[1:0])) begin
              fault_q <= 1'b1;
              cause_q <= CAUSE_MISALIGNED;
            end else begin
              addr_lo_q   <= eff_addr_d[1:0];
              func3_q     <= func3;
              mem_we_q    <= store_enable;
              mem_addr_q  <= {eff_addr_d[XLEN-1:2], 2'b00};
              mem_be_q    <= be_d;
              mem_wdata_q <= store_enable ? wdata_d : '0;
              mem_req_q   <= 1'b1;
              tmo_q       <= '0;
              state_q     <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            tmo_q     <= '0;
            if (mem_we_q) begin
              wb_valid_q <= 1'b1;
              wb_data_q  <= '0;
              state_q    <= ST_IDLE;
            end else begin
              state_q <= ST_WAIT_RSP;
            end
          end else if (tmo_q == TMO_LAST) begin
            mem_req_q <= 1'b0;
            fault_q   <= 1'b1;
            cause_q   <= CAUSE_TIMEOUT;
            state_q   <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        ST_WAIT_RSP: begin
          if (mem_rvalid) begin
            wb_valid_q <= 1'b1;
            wb_data_q  <= ld_data_d;
            state_q    <= ST_IDLE;
          end else if (tmo_q == TMO_LAST) begin
            fault_q <= 1'b1;
            cause_q <= CAUSE_TIMEOUT;
            state_q <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ex_ready    = (state_q == ST_IDLE);
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_be      = mem_be_q;
  assign mem_wdata   = mem_wdata_q;
  assign wb_valid    = wb_valid_q;
  assign wb_data     = wb_data_q;
  assign fault       = fault_q;
  assign fault_cause = cause_q;

endmodule

// File: tb/tb_lsu_controller.sv
// Directed bench for lsu_controller: loads, stores, stalls, faults, timeout, reset.
module tb_lsu_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0, ex_ready;
  logic        load_enable = 1'b0, store_enable = 1'b0;
  logic [31:0] base_addr = '0, imm = '0, store_data = '0;
  logic [2:0]  func3 = '0;
  logic        mem_req, mem_gnt = 1'b0, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        wb_valid, fault;
  logic [31:0] wb_data;
  logic [1:0]  fault_cause;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lsu_controller #(.TIMEOUT_CYCLES(64), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .load_enable(load_enable), .store_enable(store_enable),
    .base_addr(base_addr), .imm(imm), .store_data(store_data), .func3(func3),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_data(wb_data),
    .fault(fault), .fault_cause(fault_cause)
  );

  // Advance to the next cycle; outputs are observed and inputs driven 1ns after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic ld, input logic st, input logic [31:0] b,
                         input logic [31:0] i, input logic [31:0] sd, input logic [2:0] f3);
    ex_valid = 1'b1; load_enable = ld; store_enable = st;
    base_addr = b; imm = i; store_data = sd; func3 = f3;
  endtask

  task automatic idle_ex;
    ex_valid = 1'b0; load_enable = 1'b0; store_enable = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    n_cmp++;
    if ({mem_req, mem_we, wb_valid, fault, ex_ready} !== 5'b00001) begin
      n_bad++; $display("FAIL reset_ctrl got=%b want=00001", {mem_req, mem_we, wb_valid, fault, ex_ready});
    end
    n_cmp++;
    if ({mem_addr, mem_be, mem_wdata, wb_data, fault_cause} !== 102'd0) begin
      n_bad++; $display("FAIL reset_data addr=%h be=%b wd=%h wb=%h cause=%0d want all 0",
                        mem_addr, mem_be, mem_wdata, wb_data, fault_cause);
    end
    rst = 1'b0;
    tick;
    $display("reset: checked");
  endtask

  // Full load: accept, grant on first req cycle, rvalid the cycle after grant.
  task automatic run_load(input string name, input logic [31:0] b, input logic [31:0] i,
                          input logic [2:0] f3, input logic [31:0] rdata,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_data);
    present(1'b1, 1'b0, b, i, 32'h0, f3);
    tick;
    idle_ex;
    n_cmp++;
    if ({mem_req, mem_we, ex_ready, mem_addr, mem_be} !== {3'b100, exp_addr, exp_be}) begin
      n_bad++; $display("FAIL %s_req req=%b we=%b rdy=%b addr=%h be=%b want 1/0/0 %h %b",
                        name, mem_req, mem_we, ex_ready, mem_addr, mem_be, exp_addr, exp_be);
    end
    mem_gnt = 1'b1;
    tick;
    mem_gnt = 1'b0;
    n_cmp++;
    if ({mem_req, wb_valid, ex_ready} !== 3'b000) begin
      n_bad++; $display("FAIL %s_wait req=%b wbv=%b rdy=%b want 000", name, mem_req, wb_valid, ex_ready);
    end
    mem_rvalid = 1'b1; mem_rdata = rdata;
    tick;
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    n_cmp++;
    if ({wb_valid, ex_ready, wb_data} !== {2'b11, exp_data}) begin
      n_bad++; $display("FAIL %s_wb wbv=%b rdy=%b data=%h want 1/1 %h", name, wb_valid, ex_ready, wb_data, exp_data);
    end
    tick;
    n_cmp++;
    if (wb_valid !== 1'b0) begin
      n_bad++; $display("FAIL %s_pulse wbv=%b want 0", name, wb_valid);
    end
    $display("load %s: addr=%h be=%b wb_data=%h", name, exp_addr, exp_be, exp_data);
  endtask

  task automatic test_loads;
    run_load("lw",  32'h1000, 32'd4, 3'b010, 32'hDEADBEEF, 32'h1004, 4'b1111, 32'hDEADBEEF);
    run_load("lb",  32'h2000, 32'd3, 3'b000, 32'h80FF0000, 32'h2000, 4'b1000, 32'hFFFFFF80);
    run_load("lbu", 32'h2000, 32'd3, 3'b100, 32'h80FF0000, 32'h2000, 4'b1000, 32'h00000080);
    run_load("lhu", 32'h2010, 32'hFFFFFFF2, 3'b101, 32'h8001_7F02, 32'h2000, 4'b1100, 32'h00008001);
  endtask

  task automatic test_store_stall;
    present(1'b0, 1'b1, 32'h3000, 32'd2, 32'h1234ABCD, 3'b001);
    tick;
    idle_ex;
    for (int k = 1; k <= 5; k++) begin
      n_cmp++;
      if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata, wb_valid} !==
          {2'b11, 32'h3000, 4'b1100, 32'hABCDABCD, 1'b0}) begin
        n_bad++; $display("FAIL sh_stall%0d req=%b we=%b addr=%h be=%b wd=%h wbv=%b want 1 1 3000 1100 abcdabcd 0",
                          k, mem_req, mem_we, mem_addr, mem_be, mem_wdata, wb_valid);
      end
      tick;
    end
    mem_gnt = 1'b1;
    n_cmp++;
    if ({mem_req, wb_valid} !== 2'b10) begin
      n_bad++; $display("FAIL sh_gnt req=%b wbv=%b want 10", mem_req, wb_valid);
    end
    tick;
    mem_gnt = 1'b0;
    n_cmp++;
    if ({wb_valid, mem_req, ex_ready, wb_data} !== {3'b101, 32'h0}) begin
      n_bad++; $display("FAIL sh_wb wbv=%b req=%b rdy=%b data=%h want 1 0 1 0", wb_valid, mem_req, ex_ready, wb_data);
    end
    tick;
    $display("store sh: addr=3000 be=1100 wdata=abcdabcd after 5 stall cycles");
  endtask

  // Store completes and a load is accepted in the same cycle wb_valid is high.
  task automatic test_back_to_back;
    present(1'b0, 1'b1, 32'h5000, 32'd1, 32'h000000A5, 3'b000);
    tick;
    idle_ex;
    n_cmp++;
    if ({mem_be, mem_wdata} !== {4'b0010, 32'hA5A5A5A5}) begin
      n_bad++; $display("FAIL b2b_sb be=%b wd=%h want 0010 a5a5a5a5", mem_be, mem_wdata);
    end
    mem_gnt = 1'b1;
    tick;
    mem_gnt = 1'b0;
    n_cmp++;
    if ({wb_valid, ex_ready} !== 2'b11) begin
      n_bad++; $display("FAIL b2b_wb wbv=%b rdy=%b want 11", wb_valid, ex_ready);
    end
    present(1'b1, 1'b0, 32'h5000, 32'd2, 32'h0, 3'b001);
    tick;
    idle_ex;
    n_cmp++;
    if ({mem_req, mem_we, mem_addr, mem_be} !== {2'b10, 32'h5000, 4'b1100}) begin
      n_bad++; $display("FAIL b2b_lh_req req=%b we=%b addr=%h be=%b want 1 0 5000 1100", mem_req, mem_we, mem_addr, mem_be);
    end
    mem_gnt = 1'b1;
    tick;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h8001_0000;
    tick;
    mem_rvalid = 1'b0;
    n_cmp++;
    if ({wb_valid, wb_data} !== {1'b1, 32'hFFFF8001}) begin
      n_bad++; $display("FAIL b2b_lh_wb wbv=%b data=%h want 1 ffff8001", wb_valid, wb_data);
    end
    tick;
    $display("back_to_back: sb then lh accepted on wb cycle");
  endtask

  task automatic test_faults;
    logic seen_req;
    present(1'b1, 1'b0, 32'h4000, 32'd1, 32'h0, 3'b010);
    tick;
    idle_ex;
    n_cmp++;
    if ({fault, fault_cause, mem_req, ex_ready} !== 5'b1_00_0_1) begin
      n_bad++; $display("FAIL misalign_lw fault=%b cause=%0d req=%b rdy=%b want 1 0 0 1", fault, fault_cause, mem_req, ex_ready);
    end
    seen_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      seen_req |= mem_req;
      tick;
    end
    n_cmp++;
    if ({seen_req, fault, fault_cause} !== 4'b0_0_00) begin
      n_bad++; $display("FAIL misalign_after req_seen=%b fault=%b cause=%0d want 0 0 0", seen_req, fault, fault_cause);
    end
    present(1'b0, 1'b1, 32'h4000, 32'd0, 32'h0, 3'b011);
    tick;
    idle_ex;
    n_cmp++;
    if ({fault, fault_cause, mem_req} !== 4'b1_01_0) begin
      n_bad++; $display("FAIL illegal_st fault=%b cause=%0d req=%b want 1 1 0", fault, fault_cause, mem_req);
    end
    present(1'b0, 1'b0, 32'h4000, 32'd0, 32'h0, 3'b010);
    tick;
    idle_ex;
    n_cmp++;
    if ({fault, fault_cause, mem_req} !== 4'b0_01_0) begin
      n_bad++; $display("FAIL no_enable fault=%b cause=%0d req=%b want 0 1 0", fault, fault_cause, mem_req);
    end
    present(1'b1, 1'b0, 32'h4000, 32'd3, 32'h0, 3'b001);
    tick;
    idle_ex;
    n_cmp++;
    if ({fault, fault_cause} !== 3'b1_00) begin
      n_bad++; $display("FAIL misalign_lh fault=%b cause=%0d want 1 0", fault, fault_cause);
    end
    present(1'b1, 1'b1, 32'h4000, 32'd0, 32'h0, 3'b010);
    tick;
    idle_ex;
    n_cmp++;
    if ({fault, fault_cause, mem_req} !== 4'b1_01_0) begin
      n_bad++; $display("FAIL both_en fault=%b cause=%0d req=%b want 1 1 0", fault, fault_cause, mem_req);
    end
    tick;
    $display("faults: misaligned/illegal/both-enables checked");
  endtask

  task automatic test_timeout;
    int n;
    present(1'b1, 1'b0, 32'h6000, 32'd0, 32'h0, 3'b010);
    tick;
    idle_ex;
    mem_gnt = 1'b1;
    tick;
    mem_gnt = 1'b0;
    n = 1;
    n_cmp++;
    if ({mem_req, ex_ready} !== 2'b00) begin
      n_bad++; $display("FAIL tmo_wait req=%b rdy=%b want 00", mem_req, ex_ready);
    end
    while (fault !== 1'b1 && n < 100) begin
      tick;
      n++;
    end
    n_cmp++;
    if (n !== 65) begin
      n_bad++; $display("FAIL tmo_cycles fault seen %0d cycles after gnt, want 65", n);
    end
    n_cmp++;
    if ({fault_cause, ex_ready, wb_valid} !== 4'b10_1_0) begin
      n_bad++; $display("FAIL tmo_cause cause=%0d rdy=%b wbv=%b want 2 1 0", fault_cause, ex_ready, wb_valid);
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    tick;
    mem_rvalid = 1'b0;
    tick;
    n_cmp++;
    if ({wb_valid, fault, wb_data} !== {2'b00, 32'hFFFF8001}) begin
      n_bad++; $display("FAIL tmo_late_rvalid wbv=%b fault=%b data=%h want 0 0 ffff8001", wb_valid, fault, wb_data);
    end
    $display("timeout: fault after %0d cycles, cause 2", n);
  endtask

  task automatic test_reset_mid;
    present(1'b1, 1'b0, 32'h7000, 32'd8, 32'h0, 3'b010);
    tick;
    idle_ex;
    n_cmp++;
    if (mem_req !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_req req=%b want 1", mem_req);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_cmp++;
    if ({mem_req, mem_we, wb_valid, fault, ex_ready, mem_addr, mem_be, mem_wdata, wb_data, fault_cause} !== {5'b00001, 102'd0}) begin
      n_bad++; $display("FAIL rstmid_state req=%b rdy=%b addr=%h be=%b wb=%h cause=%0d want 0 1 0 0 0 0",
                        mem_req, ex_ready, mem_addr, mem_be, wb_data, fault_cause);
    end
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick;
    mem_rvalid = 1'b0;
    n_cmp++;
    if (wb_valid !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_rvalid wbv=%b want 0", wb_valid);
    end
    run_load("lw_after_rst", 32'h7000, 32'd8, 3'b010, 32'h0BADF00D, 32'h7008, 4'b1111, 32'h0BADF00D);
    $display("reset_mid: recovered");
  endtask

  initial begin
    test_reset;
    test_loads;
    test_store_stall;
    test_back_to_back;
    test_faults;
    test_timeout;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
